// File: rtl/bcd_step_decoder.sv
// Receive-side decoder for a mod-10 up/down BCD counter: recovers direction,
// decade carry/borrow, an extended BCD count and flags illegal codes or jumps.
module bcd_step_decoder #(
    parameter int TENS_DIGITS = 2,
    parameter int LOCK_COUNT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [3:0]               q,
    input  logic                     cnt_clear,
    output logic                     locked,
    output logic                     dir,
    output logic                     hold,
    output logic                     carry,
    output logic                     borrow,
    output logic                     wrap,
    output logic                     err,
    output logic [7:0]               err_count,
    output logic [4*TENS_DIGITS-1:0] count_hi,
    output logic [3:0]               digit
);

    localparam int HW = 4 * TENS_DIGITS;
    localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t          state_r;
    logic            locked_r;
    logic            dir_r;
    logic            hold_r;
    logic            carry_r;
    logic            borrow_r;
    logic            wrap_r;
    logic            err_r;
    logic [7:0]      err_count_r;
    logic [HW-1:0]   count_hi_r;
    logic [3:0]      digit_r;
    logic [3:0]      streak_r;

    logic            illegal_s;
    logic            up_s;
    logic            down_s;
    logic            same_s;
    logic [3:0]      streak_inc_s;

    function automatic logic [HW-1:0] bcd_inc(input logic [HW-1:0] v);
        logic [HW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < TENS_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [HW-1:0] bcd_dec(input logic [HW-1:0] v);
        logic [HW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < TENS_DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_all_nines(input logic [HW-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < TENS_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Classify the incoming sample against the last accepted digit.
    always_comb begin
        illegal_s    = (q > 4'd9);
        up_s         = (q == ((digit_r == 4'd9) ? 4'd0 : digit_r + 4'd1));
        down_s       = (q == ((digit_r == 4'd0) ? 4'd9 : digit_r - 4'd1));
        same_s       = (q == digit_r);
        streak_inc_s = streak_r + 4'd1;
    end

    // Lock state machine, extended count and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= UNLOCKED;
            locked_r    <= 1'b0;
            dir_r       <= 1'b0;
            hold_r      <= 1'b0;
            carry_r     <= 1'b0;
            borrow_r    <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
            count_hi_r  <= '0;
            digit_r     <= 4'd0;
            streak_r    <= 4'd0;
        end else begin
            hold_r   <= 1'b0;
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
            wrap_r   <= 1'b0;
            err_r    <= 1'b0;
            if (sample_valid) begin
                if (illegal_s) begin
                    err_r       <= 1'b1;
                    err_count_r <= sat_inc8(err_count_r);
                    state_r     <= UNLOCKED;
                    locked_r    <= 1'b0;
                    streak_r    <= 4'd0;
                end else begin
                    case (state_r)
                        UNLOCKED: begin
                            digit_r  <= q;
                            streak_r <= 4'd0;
                            state_r  <= ACQUIRE;
                        end
                        ACQUIRE: begin
                            if (up_s || down_s) begin
                                streak_r <= streak_inc_s;
                                dir_r    <= down_s;
                                digit_r  <= q;
                                if (streak_inc_s >= LOCK_LIM) begin
                                    state_r  <= LOCKED;
                                    locked_r <= 1'b1;
                                end
                            end else if (same_s) begin
                                hold_r <= 1'b1;
                            end else begin
                                digit_r  <= q;
                                streak_r <= 4'd0;
                            end
                        end
                        LOCKED: begin
                            if (up_s) begin
                                dir_r   <= 1'b0;
                                digit_r <= q;
                                if (digit_r == 4'd9) begin
                                    carry_r    <= 1'b1;
                                    count_hi_r <= bcd_inc(count_hi_r);
                                    wrap_r     <= bcd_all_nines(count_hi_r);
                                end
                            end else if (down_s) begin
                                dir_r   <= 1'b1;
                                digit_r <= q;
                                if (digit_r == 4'd0) begin
                                    borrow_r   <= 1'b1;
                                    count_hi_r <= bcd_dec(count_hi_r);
                                    wrap_r     <= (count_hi_r == '0);
                                end
                            end else if (same_s) begin
                                hold_r <= 1'b1;
                            end else begin
                                err_r       <= 1'b1;
                                err_count_r <= sat_inc8(err_count_r);
                                digit_r     <= q;
                                streak_r    <= 4'd0;
                                state_r     <= ACQUIRE;
                                locked_r    <= 1'b0;
                            end
                        end
                        default: begin
                            state_r  <= UNLOCKED;
                            locked_r <= 1'b0;
                            streak_r <= 4'd0;
                        end
                    endcase
                end
            end
            // Clear overrides any increment made by the same sample.
            if (cnt_clear) begin
                count_hi_r  <= '0;
                err_count_r <= 8'd0;
            end
        end
    end

    assign locked    = locked_r;
    assign dir       = dir_r;
    assign hold      = hold_r;
    assign carry     = carry_r;
    assign borrow    = borrow_r;
    assign wrap      = wrap_r;
    assign err       = err_r;
    assign err_count = err_count_r;
    assign count_hi  = count_hi_r;
    assign digit     = digit_r;

endmodule

// File: tb/tb_bcd_step_decoder.sv
// Directed plus randomized bench for bcd_step_decoder against an integer
// reference model of the step/lock/count rules.
module tb_bcd_step_decoder;

    localparam int TD  = 2;
    localparam int LC  = 2;
    localparam int LIM = 100;

    logic          clk;
    logic          reset;
    logic          sample_valid;
    logic [3:0]    q;
    logic          cnt_clear;
    logic          locked;
    logic          dir;
    logic          hold;
    logic          carry;
    logic          borrow;
    logic          wrap;
    logic          err;
    logic [7:0]    err_count;
    logic [4*TD-1:0] count_hi;
    logic [3:0]    digit;

    int vectors;
    int miscompares;

    // reference model: 0 unlocked, 1 acquire, 2 locked
    int m_state, m_prev, m_streak, m_dir, m_count, m_errc;
    int m_hold, m_carry, m_borrow, m_wrap, m_err;

    bcd_step_decoder #(.TENS_DIGITS(TD), .LOCK_COUNT(LC)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .q(q),
        .cnt_clear(cnt_clear), .locked(locked), .dir(dir), .hold(hold),
        .carry(carry), .borrow(borrow), .wrap(wrap), .err(err),
        .err_count(err_count), .count_hi(count_hi), .digit(digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*TD-1:0] to_bcd(input int v);
        logic [4*TD-1:0] r;
        int t;
        t = v;
        for (int i = 0; i < TD; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked", 32'(locked), 32'(m_state == 2));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("hold", 32'(hold), 32'(m_hold));
        chk("carry", 32'(carry), 32'(m_carry));
        chk("borrow", 32'(borrow), 32'(m_borrow));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_errc));
        chk("count_hi", 32'(count_hi), 32'(to_bcd(m_count)));
        chk("digit", 32'(digit), 32'(m_prev));
    endtask

    task automatic model_step(input int sv, input int c, input int clr);
        m_hold = 0; m_carry = 0; m_borrow = 0; m_wrap = 0; m_err = 0;
        if (sv != 0) begin
            if (c > 9) begin
                m_err = 1;
                m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                m_state = 0;
                m_streak = 0;
            end else begin
                bit is_up, is_dn, is_hd;
                is_up = (c == (m_prev + 1) % 10);
                is_dn = (c == (m_prev + 9) % 10);
                is_hd = (c == m_prev);
                if (m_state == 0) begin
                    m_prev = c; m_streak = 0; m_state = 1;
                end else if (m_state == 1) begin
                    if (is_up || is_dn) begin
                        m_streak++;
                        m_dir = is_dn ? 1 : 0;
                        m_prev = c;
                        if (m_streak >= LC) m_state = 2;
                    end else if (is_hd) begin
                        m_hold = 1;
                    end else begin
                        m_prev = c; m_streak = 0;
                    end
                end else begin
                    if (is_up) begin
                        m_dir = 0;
                        if (m_prev == 9) begin
                            m_carry = 1;
                            m_count = (m_count + 1) % LIM;
                            m_wrap = (m_count == 0) ? 1 : 0;
                        end
                        m_prev = c;
                    end else if (is_dn) begin
                        m_dir = 1;
                        if (m_prev == 0) begin
                            m_borrow = 1;
                            m_wrap = (m_count == 0) ? 1 : 0;
                            m_count = (m_count + LIM - 1) % LIM;
                        end
                        m_prev = c;
                    end else if (is_hd) begin
                        m_hold = 1;
                    end else begin
                        m_err = 1;
                        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                        m_prev = c; m_streak = 0; m_state = 1;
                    end
                end
            end
        end
        if (clr != 0) begin
            m_count = 0;
            m_errc = 0;
        end
    endtask

    task automatic apply(input int sv, input int c, input int clr);
        @(negedge clk);
        sample_valid = (sv != 0);
        q = 4'(c);
        cnt_clear = (clr != 0);
        @(posedge clk);
        model_step(sv, c, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        cnt_clear = 1'b0;
        @(posedge clk);
        m_state = 0; m_prev = 0; m_streak = 0; m_dir = 0; m_count = 0; m_errc = 0;
        m_hold = 0; m_carry = 0; m_borrow = 0; m_wrap = 0; m_err = 0;
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        sample_valid = 1'b0;
        q = 4'd0;
        cnt_clear = 1'b0;

        // lock-up and up carry
        do_reset();
        apply(1, 3, 0); apply(1, 4, 0); apply(1, 5, 0);
        for (int v = 6; v <= 10; v++) apply(1, v % 10, 0);
        // 99 more decades: count_hi wraps 99 -> 00
        for (int d = 0; d < 99; d++)
            for (int v = 1; v <= 10; v++) apply(1, v % 10, 0);

        // down borrow with wrap, then reversal back up
        do_reset();
        apply(1, 3, 0); apply(1, 2, 0); apply(1, 1, 0);
        apply(1, 0, 0); apply(1, 9, 0);
        apply(1, 0, 0); apply(1, 1, 0);

        // errors: locked jump, illegal code, acquire jump, saturation
        do_reset();
        apply(1, 2, 0); apply(1, 3, 0); apply(1, 4, 0);
        apply(1, 7, 0);
        apply(1, 12, 0);
        apply(1, 3, 0); apply(1, 8, 0);
        for (int i = 0; i < 300; i++) apply(1, $urandom_range(10, 15), 0);

        // hold and idle
        apply(1, 3, 0); apply(1, 4, 0); apply(1, 5, 0);
        apply(1, 5, 0); apply(1, 5, 0); apply(1, 5, 0);
        for (int i = 0; i < 10; i++) apply(0, $urandom_range(0, 15), 0);

        // clear collides with carry and a pending error count
        apply(1, 6, 0); apply(1, 7, 0); apply(1, 8, 0); apply(1, 9, 0);
        apply(1, 0, 1);
        apply(1, 1, 0); apply(1, 2, 0); apply(1, 3, 0);
        for (int v = 4; v <= 10; v++) apply(1, v % 10, 0);
        do_reset();
        apply(1, 5, 0);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            int r, c;
            r = $urandom_range(0, 19);
            if (r < 7)       c = (m_prev + 1) % 10;
            else if (r < 13) c = (m_prev + 9) % 10;
            else if (r < 15) c = m_prev;
            else if (r < 17) c = $urandom_range(0, 15);
            else             c = $urandom_range(0, 9);
            if ($urandom_range(0, 199) == 0) do_reset();
            apply(($urandom_range(0, 9) != 0) ? 1 : 0, c,
                  ($urandom_range(0, 49) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_step_decoder.md
Name: bcd_step_decoder

Overview:
- Receive-side companion to the team's mod-10 up/down T-flip-flop counter. Samples that counter's 4-bit BCD output and recovers direction, decade carry/borrow events, and an extended multi-digit count.
- Validates that each sample is a legal single step (+1/-1 mod 10, or hold). Flags illegal codes and jumps.
- Sits between counter outputs and display/monitor logic; fully synchronous to the counter clock.

Parameters:
- TENS_DIGITS, 2, number of higher-order BCD digits accumulated above the sampled digit.
- LOCK_COUNT, 2, consecutive legal steps required before leaving ACQUIRE (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  q is sampled this cycle.
- q  in  4  BCD digit from counter (q[4:1], q[1] = LSB).
- cnt_clear  in  1  synchronous clear of count_hi and err_count.
- locked  out  1  high in LOCKED state.
- dir  out  1  last recovered direction: 0 = up, 1 = down (matches counter reverse).
- hold  out  1  1-cycle pulse: valid sample equal to previous.
- carry  out  1  1-cycle pulse: locked step 9→0.
- borrow  out  1  1-cycle pulse: locked step 0→9.
- wrap  out  1  1-cycle pulse: count_hi wrapped (all-9s→0 or 0→all-9s).
- err  out  1  1-cycle pulse: illegal code or illegal jump.
- err_count  out  8  saturating error counter.
- count_hi  out  4*TENS_DIGITS  BCD upper digits.
- digit  out  4  last accepted legal sample.

Behaviour:
- Reset (has priority over everything):
  - State = UNLOCKED.
  - All outputs = 0; streak = 0; prev/digit = 0.
- Outputs are registered. The response to a sample appears the cycle after sample_valid is high.
- sample_valid low: state, digit, count_hi and err_count hold; all pulses = 0.
- Step classification, with p = prev, c = q:
  - UP if c == (p+1) mod 10.
  - DOWN if c == (p+9) mod 10.
  - HOLD if c == p.
  - JUMP otherwise.
- Illegal code (q > 9), in any state:
  - err = 1; err_count += 1 (saturates at 255).
  - State → UNLOCKED; digit unchanged.
- UNLOCKED, legal q: prev = digit = q; streak = 0; → ACQUIRE. No err.
- ACQUIRE:
  - UP/DOWN: streak += 1; dir updated; prev = digit = q. When streak reaches LOCK_COUNT → LOCKED.
  - HOLD: hold pulse; streak unchanged.
  - JUMP: prev = digit = q; streak = 0; stay in ACQUIRE; no err.
  - carry/borrow are never issued in ACQUIRE; count_hi is unchanged.
- LOCKED:
  - UP: dir = 0. If p = 9: carry = 1 and count_hi BCD-increments; all-9s → 0 with wrap = 1.
  - DOWN: dir = 1. If p = 0: borrow = 1 and count_hi BCD-decrements; 0 → all-9s with wrap = 1.
  - Direction reversal is legal and stays locked.
  - HOLD: hold = 1; nothing else changes.
  - JUMP: err = 1; err_count += 1 (saturating); prev = digit = q; streak = 0; → ACQUIRE.
- BCD arithmetic: per-digit 0..9 with ripple carry/borrow across digits. Every count_hi nibble always holds ≤ 9.
- cnt_clear (when reset is low):
  - count_hi = 0 and err_count = 0 next cycle; wins over the same-cycle carry/borrow/error increment.
  - Pulses and state machine still process the sample normally.
- Mid-operation reset: discards lock and count. The first sample after reset only seeds prev.

Test Plan:
- Lock-up: reset, then samples 3,4,5 (LOCK_COUNT=2) → locked = 1 the cycle after sample 5; dir = 0; digit = 5; no err.
- Up carry and wrap:
  - Locked, samples 8,9,0 → carry high exactly 1 cycle; count_hi 0x00→0x01.
  - Drive 100 decades → count_hi 0x99→0x00 with wrap = 1 on that carry.
- Down borrow:
  - From reset, lock with 3,2,1, then samples 0,9 → dir = 1; borrow pulse; count_hi 0x00→0x99; wrap = 1.
  - Then 9,0,1 (reversal) → stays locked; no err; carry on 9→0 returns count_hi to 0x00 with wrap.
- Errors:
  - Locked at 4, sample 7 → err 1 cycle; err_count = 1; locked = 0; digit = 7.
  - Sample 12 → err; err_count = 2; UNLOCKED.
  - Jump while in ACQUIRE → no err.
  - Force 300 errors → err_count = 255.
- Hold and idle:
  - Locked, samples 5,5,5 → hold pulse per sample; no carry/borrow.
  - sample_valid low 10 cycles → all outputs stable, pulses 0.
- Clear collision: locked at 9, sample 0 with cnt_clear = 1 → carry = 1 but count_hi = 0x00 and err_count = 0. Reset asserted mid-lock → locked = 0, count_hi = 0 next cycle.
